// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the W-stage trap sequencer.
// Holds the trap kind encoding, FSM states and the default drain watchdog limit.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        KIND_EXC  = 2'd0,
        KIND_INT  = 2'd1,
        KIND_CSR  = 2'd2,
        KIND_MRET = 2'd3
    } trap_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    localparam int DRAIN_MAX_DEFAULT = 255;

    // A CSR write resumes at the next sequential instruction.
    localparam logic [63:0] CSR_PC_STEP = 64'd4;

endpackage

// File: rtl/trap_sequencer_if.sv
// Signal bundle between the trap sequencer and its environment (W stage, CSR file, buses, fetch).
// The sequencer uses the slave modport; the pipeline side uses master.
interface trap_sequencer_if;

    logic        wb_valid;
    logic [63:0] wb_pc;
    logic        wb_exc;
    logic        wb_csr_write;
    logic        wb_mret;
    logic        int_pending;
    logic        mem_busy;
    logic        fetch_busy;
    logic [63:0] trap_vec;
    logic [63:0] ret_pc;
    logic        stall_pipe;
    logic        csr_commit;
    logic [1:0]  commit_kind;
    logic [63:0] commit_pc;
    logic        flush;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        redirect_ready;
    logic        drain_timeout;

    modport master (
        output wb_valid, wb_pc, wb_exc, wb_csr_write, wb_mret, int_pending,
               mem_busy, fetch_busy, trap_vec, ret_pc, redirect_ready,
        input  stall_pipe, csr_commit, commit_kind, commit_pc, flush,
               redirect_valid, redirect_pc, drain_timeout
    );

    modport slave (
        input  wb_valid, wb_pc, wb_exc, wb_csr_write, wb_mret, int_pending,
               mem_busy, fetch_busy, trap_vec, ret_pc, redirect_ready,
        output stall_pipe, csr_commit, commit_kind, commit_pc, flush,
               redirect_valid, redirect_pc, drain_timeout
    );

endinterface

// File: rtl/trap_sequencer.sv
// Serialises control-flow side effects at W: freeze, drain the buses, one CSR commit cycle,
// flush, then a held PC redirect to fetch until it is accepted.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    trap_sequencer_if.slave bus
);

    localparam int               CNT_W    = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    trap_state_t      state_q, state_d;
    trap_kind_t       kind_q, kind_d, evt_kind_s;
    logic [63:0]      pc_q, pc_d;
    logic [63:0]      tgt_q, tgt_d, target_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_s, busy_s;
    logic             stall_s, commit_s, redir_s, timeout_s;

    assign evt_s  = bus.wb_valid & (bus.wb_exc | bus.int_pending | bus.wb_csr_write | bus.wb_mret);
    assign busy_s = bus.mem_busy | bus.fetch_busy;

    // Priority encoder: exc > int > csr > mret.
    always_comb begin
        evt_kind_s = KIND_EXC;
        if (bus.wb_exc) begin
            evt_kind_s = KIND_EXC;
        end else if (bus.int_pending) begin
            evt_kind_s = KIND_INT;
        end else if (bus.wb_csr_write) begin
            evt_kind_s = KIND_CSR;
        end else if (bus.wb_mret) begin
            evt_kind_s = KIND_MRET;
        end else begin
            evt_kind_s = KIND_EXC;
        end
    end

    // Redirect target, sampled in COMMIT before the CSR update becomes visible.
    always_comb begin
        target_s = bus.trap_vec;
        case (kind_q)
            KIND_EXC, KIND_INT: target_s = bus.trap_vec;
            KIND_CSR:           target_s = pc_q + CSR_PC_STEP;
            KIND_MRET:          target_s = bus.ret_pc;
            default:            target_s = bus.trap_vec;
        endcase
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        cnt_d     = {CNT_W{1'b0}};
        stall_s   = 1'b0;
        commit_s  = 1'b0;
        redir_s   = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (evt_s) begin
                    kind_d  = evt_kind_s;
                    pc_d    = bus.wb_pc;
                    stall_s = 1'b1;
                    if (busy_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                stall_s = 1'b1;
                if (!busy_s) begin
                    state_d = ST_COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog expired: commit anyway rather than hang on a stuck bus.
                    state_d   = ST_COMMIT;
                    timeout_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_COMMIT: begin
                stall_s  = 1'b1;
                commit_s = 1'b1;
                tgt_d    = target_s;
                state_d  = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                stall_s = 1'b1;
                redir_s = 1'b1;
                if (bus.redirect_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REDIRECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, event latch, redirect target and watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_EXC;
            pc_q    <= 64'd0;
            tgt_q   <= 64'd0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_pipe     = stall_s;
    assign bus.csr_commit     = commit_s;
    assign bus.flush          = commit_s;
    assign bus.commit_kind    = commit_s ? kind_q : KIND_EXC;
    assign bus.commit_pc      = commit_s ? pc_q : 64'd0;
    assign bus.redirect_valid = redir_s;
    assign bus.redirect_pc    = redir_s ? tgt_q : 64'd0;
    assign bus.drain_timeout  = timeout_s;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus pushes the expected commit/redirect timeline,
// a negedge monitor compares every output cycle by cycle against the queue head.
module tb_trap_sequencer;

    localparam int DMAX = 8;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    bit   reset_prev;

    trap_sequencer_if bus ();

    trap_sequencer #(.DRAIN_MAX(DMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          ev;
        int          cc;
        int          hs;
        logic [1:0]  kind;
        logic [63:0] pc;
        logic [63:0] tgt;
        bit          to;
    } exp_t;

    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: derive expected outputs from the queue head and compare.
    always @(negedge clk) begin
        exp_t e;
        bit   e_stall, e_commit, e_rv, e_to;
        if (cyc >= 1) begin
            e_stall  = 1'b0;
            e_commit = 1'b0;
            e_rv     = 1'b0;
            e_to     = 1'b0;
            if (q.size() > 0) begin
                e        = q[0];
                e_stall  = (cyc >= e.ev) && (cyc <= e.hs);
                e_commit = (cyc == e.cc);
                e_rv     = (cyc > e.cc) && (cyc <= e.hs);
                e_to     = e.to && (cyc == e.cc - 1);
            end
            chk("stall_pipe", 64'(bus.stall_pipe), 64'(e_stall));
            chk("csr_commit", 64'(bus.csr_commit), 64'(e_commit));
            chk("flush", 64'(bus.flush), 64'(e_commit));
            chk("redirect_valid", 64'(bus.redirect_valid), 64'(e_rv));
            chk("drain_timeout", 64'(bus.drain_timeout), 64'(e_to));
            if (e_commit) begin
                chk("commit_kind", 64'(bus.commit_kind), 64'(e.kind));
                chk("commit_pc", bus.commit_pc, e.pc);
            end
            if (e_rv) begin
                chk("redirect_pc", bus.redirect_pc, e.tgt);
            end
            if (reset_prev) begin
                chk("reset_commit_kind", 64'(bus.commit_kind), 64'd0);
                chk("reset_commit_pc", bus.commit_pc, 64'd0);
                chk("reset_redirect_pc", bus.redirect_pc, 64'd0);
            end
            if ((q.size() > 0) && (cyc == e.hs)) begin
                void'(q.pop_front());
            end
            if (reset) begin
                q.delete();
            end
            reset_prev = reset;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.wb_valid       = 1'b0;
        bus.wb_exc         = 1'b0;
        bus.wb_csr_write   = 1'b0;
        bus.wb_mret        = 1'b0;
        bus.int_pending    = 1'b0;
        bus.mem_busy       = 1'b0;
        bus.fetch_busy     = 1'b0;
        bus.redirect_ready = 1'b0;
    endtask

    // Arbitrary traffic that must be ignored while the sequencer is busy.
    task automatic junk();
        bus.wb_valid     = 1'($urandom_range(0, 1));
        bus.wb_exc       = 1'($urandom_range(0, 1));
        bus.wb_csr_write = 1'($urandom_range(0, 1));
        bus.wb_mret      = 1'($urandom_range(0, 1));
        bus.int_pending  = 1'($urandom_range(0, 1));
        bus.wb_pc        = {$urandom(), $urandom()};
    endtask

    task automatic idle_cycles(input int n, input bit force_int);
        for (int i = 0; i < n; i++) begin
            quiet();
            bus.int_pending  = force_int ? 1'b1 : 1'($urandom_range(0, 1));
            bus.wb_exc       = 1'($urandom_range(0, 1));
            bus.mem_busy     = 1'($urandom_range(0, 1));
            bus.wb_pc        = {$urandom(), $urandom()};
            step();
        end
        quiet();
    endtask

    // One event: b = busy cycles starting at the event cycle, r = ready-low cycles in REDIRECT,
    // abort_k >= 0 asserts reset in the (abort_k)th REDIRECT cycle.
    task automatic run_txn(input bit exc, input bit ip, input bit csr, input bit mr,
                           input logic [63:0] pc, input logic [63:0] tv, input logic [63:0] rp,
                           input int b, input int r, input int abort_k);
        exp_t e;
        int   drain;
        int   abort_t;
        logic [1:0] sel;
        e.ev  = cyc;
        drain = (b > DMAX) ? DMAX : b;
        e.to  = (b > DMAX);
        e.cc  = e.ev + 1 + drain;
        e.hs  = e.cc + 1 + r;
        if (exc)      e.kind = 2'd0;
        else if (ip)  e.kind = 2'd1;
        else if (csr) e.kind = 2'd2;
        else          e.kind = 2'd3;
        e.pc = pc;
        if (e.kind == 2'd3)      e.tgt = rp;
        else if (e.kind == 2'd2) e.tgt = pc + 64'd4;
        else                     e.tgt = tv;
        abort_t = (abort_k >= 0) ? (e.cc + 1 + abort_k) : -1;
        q.push_back(e);
        bus.trap_vec = tv;
        bus.ret_pc   = rp;
        for (int t = e.ev; t <= e.hs; t++) begin
            if (t == e.ev) begin
                bus.wb_valid     = 1'b1;
                bus.wb_exc       = exc;
                bus.int_pending  = ip;
                bus.wb_csr_write = csr;
                bus.wb_mret      = mr;
                bus.wb_pc        = pc;
            end else begin
                junk();
            end
            if (t - e.ev < b) begin
                sel            = 2'($urandom_range(1, 3));
                bus.mem_busy   = sel[0];
                bus.fetch_busy = sel[1];
            end else if (t <= e.cc) begin
                bus.mem_busy   = 1'b0;
                bus.fetch_busy = 1'b0;
            end else begin
                bus.mem_busy   = 1'($urandom_range(0, 1));
                bus.fetch_busy = 1'($urandom_range(0, 1));
            end
            if (t > e.cc) bus.redirect_ready = (t == e.hs);
            else          bus.redirect_ready = 1'($urandom_range(0, 1));
            if (t == abort_t) begin
                bus.wb_valid = 1'b0;
                reset        = 1'b1;
                step();
                reset = 1'b0;
                break;
            end
            step();
        end
        quiet();
    endtask

    initial begin
        bit   f_exc, f_int, f_csr, f_mr;
        logic [3:0] flags;
        logic [63:0] rpc;
        reset        = 1'b1;
        bus.wb_pc    = 64'd0;
        bus.trap_vec = 64'd0;
        bus.ret_pc   = 64'd0;
        quiet();
        repeat (3) step();
        reset = 1'b0;
        step();

        // Exception, no busy, immediate ready.
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0010, 64'h8000_0100, 64'h8000_0200, 0, 0, -1);
        idle_cycles(2, 1'b0);
        // CSR write draining behind 4 busy cycles.
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0020, 64'h8000_0100, 64'h8000_0200, 4, 0, -1);
        idle_cycles(1, 1'b0);
        // exc, int and csr together: exc wins, single commit.
        run_txn(1'b1, 1'b1, 1'b1, 1'b0, 64'h8000_0030, 64'h8000_0180, 64'h8000_0200, 0, 1, -1);
        idle_cycles(3, 1'b0);
        // Interrupt only taken with a valid W instruction.
        idle_cycles(5, 1'b1);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0040, 64'h8000_0100, 64'h8000_0200, 0, 0, -1);
        // mret with three cycles of backpressure.
        run_txn(1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0050, 64'h8000_0100, 64'h8000_0200, 0, 3, -1);
        idle_cycles(1, 1'b0);
        // Stuck bus: watchdog forces the commit after DMAX drain cycles.
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0060, 64'h8000_0100, 64'h8000_0200, 30, 0, -1);
        // Busy exactly DMAX cycles drains normally.
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0070, 64'h8000_0300, 64'h8000_0200, DMAX, 0, -1);
        // CSR pc + 4 wraps around.
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h0, 0, 0, -1);
        // Reset during REDIRECT, then a normal event afterwards.
        run_txn(1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0080, 64'h8000_0100, 64'h8000_0400, 0, 6, 2);
        idle_cycles(3, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0090, 64'h8000_0500, 64'h8000_0200, 1, 0, -1);

        for (int n = 0; n < 150; n++) begin
            flags = 4'($urandom_range(1, 15));
            f_exc = flags[0];
            f_int = flags[1];
            f_csr = flags[2];
            f_mr  = flags[3];
            rpc   = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom(), $urandom()};
            run_txn(f_exc, f_int, f_csr, f_mr, rpc, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 4)), -1);
            idle_cycles(int'($urandom_range(0, 3)), 1'b0);
        end

        idle_cycles(3, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
